// File: rtl/cntr_arb_if.sv
// cntr_arb_if: bundles the bank-scheduler side and command-generator side
// signals of the bank arbiter. The arbiter uses the master view and its
// environment (bank schedulers plus command generator) the slave view.
interface cntr_arb_if #(
    parameter int BANKS   = 4,
    parameter int DQ      = 16,
    parameter int IDX     = 7,
    parameter int RA      = 16,
    parameter int CA      = 10,
    parameter int WR_BITS = 3
);
    localparam int BW = $clog2(BANKS);

    // bank scheduler side
    logic [BANKS-1:0]         valid_i;
    logic [BANKS*DQ-1:0]      dq_i;
    logic [BANKS*IDX-1:0]     idx_i;
    logic [BANKS*RA-1:0]      ra_i;
    logic [BANKS*CA-1:0]      ca_i;
    logic [BANKS-1:0]         t_i;
    logic [BANKS-1:0]         rd_empty;
    logic [BANKS*WR_BITS-1:0] num;
    logic [BANKS-1:0]         ready_o;
    logic                     mode_o;

    // command generator side
    logic                     valid_o;
    logic                     rdy_i;
    logic [DQ-1:0]            dq_o;
    logic [IDX-1:0]           idx_o;
    logic [RA-1:0]            ra_o;
    logic [CA-1:0]            ca_o;
    logic                     t_o;
    logic [BW-1:0]            ba_o;

    modport master (
        input  valid_i, dq_i, idx_i, ra_i, ca_i, t_i, rd_empty, num, rdy_i,
        output ready_o, mode_o, valid_o, dq_o, idx_o, ra_o, ca_o, t_o, ba_o
    );

    modport slave (
        output valid_i, dq_i, idx_i, ra_i, ca_i, t_i, rd_empty, num, rdy_i,
        input  ready_o, mode_o, valid_o, dq_o, idx_o, ra_o, ca_o, t_o, ba_o
    );
endinterface

// File: rtl/cntr_arb.sv
// cntr_arb: round-robin bank arbiter with read/write bus-mode control.
// Picks one bank head whose type matches the bus mode, pops it with a
// one-hot ready, and registers it into a one-entry output stage. The bus
// mode is steered by write-drain watermarks with a turnaround gap.
module cntr_arb #(
    parameter int BANKS    = 4,
    parameter int DQ       = 16,
    parameter int IDX      = 7,
    parameter int RA       = 16,
    parameter int CA       = 10,
    parameter int WR_BITS  = 3,
    parameter int WR_HIGH  = 8,
    parameter int WR_LOW   = 2,
    parameter int TURN_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,   // active-high asynchronous reset (1 = reset)
    cntr_arb_if.master bus
);
    localparam int BW    = $clog2(BANKS);
    localparam int TOT_W = WR_BITS + BW;
    localparam int CNT_W = $clog2(TURN_CYC + 1);

    localparam logic [TOT_W-1:0] WR_HIGH_T = TOT_W'(WR_HIGH);
    localparam logic [TOT_W-1:0] WR_LOW_T  = TOT_W'(WR_LOW);
    localparam logic [TOT_W-1:0] TOT_ZERO  = {TOT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);
    localparam logic [BANKS-1:0] ONE_HOT0  = {{(BANKS-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_RD     = 2'd0;
    localparam logic [1:0] ST_TURN_W = 2'd1;
    localparam logic [1:0] ST_WR     = 2'd2;
    localparam logic [1:0] ST_TURN_R = 2'd3;

    logic [1:0]       state_r, nxt_state_s;
    logic [CNT_W-1:0] cnt_r, nxt_cnt_s;
    logic [BW-1:0]    ptr_r;
    logic             mode_r;
    logic             valid_r;
    logic [DQ-1:0]    dq_r;
    logic [IDX-1:0]   idx_r;
    logic [RA-1:0]    ra_r;
    logic [CA-1:0]    ca_r;
    logic             t_r;
    logic [BW-1:0]    ba_r;

    logic [TOT_W-1:0] wr_tot_s;
    logic             any_rd_s;
    logic             leave_s;
    logic             mode_bit_s;
    logic [BANKS-1:0] elig_s;
    logic [BW:0]      pick_s;
    logic             grant_s;
    logic [BW-1:0]    win_s;
    logic [BANKS-1:0] ready_s;

    // First eligible bank at or after ptr, wrapping; MSB of result = found.
    function automatic logic [BW:0] rr_pick(input logic [BANKS-1:0] elig,
                                            input logic [BW-1:0]    ptr);
        logic [BW-1:0] idx;
        logic [BW:0]   res;
        res = {(BW+1){1'b0}};
        for (int i = 0; i < BANKS; i++) begin
            idx = ptr + BW'(i);
            res = (!res[BW] && elig[idx]) ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // Total pending writes across banks and whether any bank still has reads.
    always_comb begin
        wr_tot_s = TOT_ZERO;
        for (int b = 0; b < BANKS; b++) begin
            wr_tot_s = wr_tot_s + TOT_W'(bus.num[b*WR_BITS +: WR_BITS]);
        end
        any_rd_s = ~&bus.rd_empty;
    end

    // Mode FSM next state; leave_s marks the cycle an active state is exited.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        leave_s     = 1'b0;
        case (state_r)
            ST_RD: begin
                if ((wr_tot_s >= WR_HIGH_T) || (!any_rd_s && (wr_tot_s != TOT_ZERO))) begin
                    nxt_state_s = ST_TURN_W;
                    nxt_cnt_s   = TURN_LOAD;
                    leave_s     = 1'b1;
                end else begin
                    nxt_state_s = ST_RD;
                end
            end
            ST_TURN_W: begin
                if (cnt_r == CNT_ZERO) begin
                    nxt_state_s = ST_WR;
                end else begin
                    nxt_cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_WR: begin
                if ((wr_tot_s == TOT_ZERO) || ((wr_tot_s <= WR_LOW_T) && any_rd_s)) begin
                    nxt_state_s = ST_TURN_R;
                    nxt_cnt_s   = TURN_LOAD;
                    leave_s     = 1'b1;
                end else begin
                    nxt_state_s = ST_WR;
                end
            end
            ST_TURN_R: begin
                if (cnt_r == CNT_ZERO) begin
                    nxt_state_s = ST_RD;
                end else begin
                    nxt_cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                nxt_state_s = ST_RD;
                nxt_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Grant selection: type-matched round-robin, gated by mode, reset and backpressure.
    always_comb begin
        mode_bit_s = (state_r == ST_WR);
        for (int b = 0; b < BANKS; b++) begin
            elig_s[b] = bus.valid_i[b] && (bus.t_i[b] == mode_bit_s);
        end
        pick_s  = rr_pick(elig_s, ptr_r);
        win_s   = pick_s[BW-1:0];
        grant_s = !rst_n && pick_s[BW] && !leave_s
                  && ((state_r == ST_RD) || (state_r == ST_WR))
                  && (!valid_r || bus.rdy_i);
        if (grant_s) begin
            ready_s = ONE_HOT0 << win_s;
        end else begin
            ready_s = {BANKS{1'b0}};
        end
    end

    // FSM state, turnaround counter, bus mode and round-robin pointer.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r <= ST_RD;
            cnt_r   <= CNT_ZERO;
            mode_r  <= 1'b0;
            ptr_r   <= {BW{1'b0}};
        end else begin
            state_r <= nxt_state_s;
            cnt_r   <= nxt_cnt_s;
            mode_r  <= (nxt_state_s != ST_RD);
            if (grant_s) begin
                ptr_r <= win_s + BW'(1);
            end
        end
    end

    // One-entry output stage: load on grant, drain on accept, hold otherwise.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            valid_r <= 1'b0;
            dq_r    <= {DQ{1'b0}};
            idx_r   <= {IDX{1'b0}};
            ra_r    <= {RA{1'b0}};
            ca_r    <= {CA{1'b0}};
            t_r     <= 1'b0;
            ba_r    <= {BW{1'b0}};
        end else if (grant_s) begin
            valid_r <= 1'b1;
            dq_r    <= bus.dq_i[int'(win_s)*DQ +: DQ];
            idx_r   <= bus.idx_i[int'(win_s)*IDX +: IDX];
            ra_r    <= bus.ra_i[int'(win_s)*RA +: RA];
            ca_r    <= bus.ca_i[int'(win_s)*CA +: CA];
            t_r     <= bus.t_i[win_s];
            ba_r    <= win_s;
        end else if (bus.rdy_i) begin
            valid_r <= 1'b0;
        end
    end

    assign bus.ready_o = ready_s;
    assign bus.mode_o  = mode_r;
    assign bus.valid_o = valid_r;
    assign bus.dq_o    = dq_r;
    assign bus.idx_o   = idx_r;
    assign bus.ra_o    = ra_r;
    assign bus.ca_o    = ca_r;
    assign bus.t_o     = t_r;
    assign bus.ba_o    = ba_r;
endmodule
